// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//   Instruction fetch stage that sits in front of the datapath. It issues
//   word-addressed fetches over a req/gnt + rvalid memory interface and keeps
//   the returned words, each tagged with its PC, in a DEPTH-entry in-order
//   queue. A redirect flushes the queue and drops any responses still in
//   flight for the old stream.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   redirect, redirect_pc flush and restart fetching at redirect_pc
//   mem_req, mem_addr     fetch request and its word address (out)
//   mem_gnt               request accepted when mem_req && mem_gnt
//   mem_rvalid, mem_rdata in-order response, at least 1 cycle after its grant
//   inst_valid, inst_ready, curr_inst, inst_pc  queue head delivery
//   queue_count           number of occupied queue entries
//   dbg_flush             1 while the FSM is in FLUSH (debug visibility)
//
// Handshakes: a transfer happens on the rising edge where valid and
// ready/gnt are both 1. A valid side never withdraws or changes its payload
// while waiting, except that a redirect or reset cancels it. mem_rvalid has
// no back-pressure: every response is taken in the cycle it is presented.
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
   parameter int unsigned      WIDTH    = 32,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   redirect,
   input  logic [WIDTH-1:0]       redirect_pc,
   output logic                   mem_req,
   output logic [WIDTH-1:0]       mem_addr,
   input  logic                   mem_gnt,
   input  logic                   mem_rvalid,
   input  logic [WIDTH-1:0]       mem_rdata,
   output logic                   inst_valid,
   input  logic                   inst_ready,
   output logic [WIDTH-1:0]       curr_inst,
   output logic [WIDTH-1:0]       inst_pc,
   output logic [$clog2(DEPTH):0] queue_count,
   output logic                   dbg_flush
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic             live_q, live_d;
   logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]    outst_q, outst_d;
   logic [CW-1:0]    discard_q, discard_d;
   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;

   logic [WIDTH-1:0] inst_mem_q [DEPTH];
   logic [WIDTH-1:0] pc_mem_q   [DEPTH];

   logic [CW:0]      fetch_sum;
   logic             grant;
   logic             deq;
   logic             wr_en;
   logic [WIDTH-1:0] resp_pc;

   // live_q keeps mem_req low while reset is asserted; it is purely a
   // registered qualifier, so mem_req/mem_addr stay free of input paths.
   assign fetch_sum = {1'b0, count_q} + {1'b0, outst_q};
   assign mem_req   = live_q && (state_q == ST_RUN) && (fetch_sum < DEPTH_W);
   assign mem_addr  = fetch_pc_q;
   assign grant     = mem_req && mem_gnt;

   assign inst_valid  = (state_q == ST_RUN) && (count_q != '0);
   assign deq         = inst_valid && inst_ready;
   assign curr_inst   = inst_valid ? inst_mem_q[rd_ptr_q] : '0;
   assign inst_pc     = inst_valid ? pc_mem_q[rd_ptr_q]   : '0;
   assign queue_count = count_q;
   assign dbg_flush   = (state_q == ST_FLUSH);

   // Requests are issued at consecutive PCs and answered in order, and a
   // redirect only returns to RUN once every older response is gone. So in
   // RUN the oldest outstanding request is always fetch_pc - outstanding.
   assign resp_pc = fetch_pc_q - WIDTH'(outst_q);

   always_comb begin
      state_d    = state_q;
      live_d     = 1'b1;
      fetch_pc_d = fetch_pc_q;
      outst_d    = outst_q + CW'(grant) - CW'(mem_rvalid);
      discard_d  = discard_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      wr_en      = 1'b0;

      if (redirect) begin
         // Everything still in flight after this edge belongs to the old
         // stream, including a request granted in this very cycle.
         fetch_pc_d = redirect_pc;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         discard_d  = outst_d;
         state_d    = (outst_d != '0) ? ST_FLUSH : ST_RUN;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (grant) begin
                  fetch_pc_d = fetch_pc_q + WIDTH'(1);
               end
               if (mem_rvalid) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + PW'(1);
               end
               if (deq) begin
                  rd_ptr_d = rd_ptr_q + PW'(1);
               end
               count_d = count_q + CW'(wr_en) - CW'(deq);
            end
            ST_FLUSH: begin
               if (mem_rvalid) begin
                  discard_d = discard_q - CW'(1);
                  if (discard_q == CW'(1)) begin
                     state_d = ST_RUN;
                  end
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_RUN;
         live_q     <= 1'b0;
         fetch_pc_q <= RESET_PC;
         outst_q    <= '0;
         discard_q  <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         live_q     <= live_d;
         fetch_pc_q <= fetch_pc_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            inst_mem_q[i] <= '0;
            pc_mem_q[i]   <= '0;
         end
      end else if (wr_en) begin
         inst_mem_q[wr_ptr_q] <= mem_rdata;
         pc_mem_q[wr_ptr_q]   <= resp_pc;
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

   localparam int W     = 32;
   localparam int DEPTH = 4;
   localparam logic [W-1:0] RESET_PC = '0;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          redirect = 1'b0;
   logic [W-1:0]  redirect_pc = '0;
   logic          mem_req;
   logic [W-1:0]  mem_addr;
   logic          mem_gnt = 1'b0;
   logic          mem_rvalid = 1'b0;
   logic [W-1:0]  mem_rdata = '0;
   logic          inst_valid;
   logic          inst_ready = 1'b0;
   logic [W-1:0]  curr_inst;
   logic [W-1:0]  inst_pc;
   logic [2:0]    queue_count;
   logic          dbg_flush;

   inst_fetch_queue #(.WIDTH(W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .curr_inst(curr_inst), .inst_pc(inst_pc),
      .queue_count(queue_count), .dbg_flush(dbg_flush)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- counters / model state ----------------
   int n_checks = 0;
   int n_fail = 0;
   int delivered = 0;
   int cyc = 0;

   // stimulus knobs (percent, redirect per-mille)
   int p_gnt = 100, p_rv = 100, p_ready = 100, p_redir = 0;
   int lat_min = 1, lat_max = 1;

   // memory model: granted addresses and earliest response cycle
   logic [W-1:0] resp_addr_q[$];
   int           resp_time_q[$];

   // reference: expected delivered PC stream and expected next fetch address
   logic [W-1:0] exp_q[$];
   logic [W-1:0] next_pc = RESET_PC;
   logic [W-1:0] exp_fetch = RESET_PC;

   logic          prev_req = 1'b0, prev_gnt = 1'b0, prev_redir = 1'b0;
   logic [W-1:0]  prev_addr = '0;

   function automatic logic [W-1:0] word_of(input logic [W-1:0] a);
      return a + 32'h100;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      resp_addr_q.delete();
      resp_time_q.delete();
      exp_q.delete();
      next_pc   = RESET_PC;
      exp_fetch = RESET_PC;
      prev_req  = 1'b0;
      prev_gnt  = 1'b0;
      prev_redir = 1'b0;
   endtask

   // ---------------- driver: one clock cycle ----------------
   task automatic drive_cycle(input bit force_redir, input logic [W-1:0] force_pc);
      int pend;
      @(negedge clk);
      cyc++;
      pend = resp_addr_q.size();
      if (rst) begin
         if (prev_req && !prev_gnt && !prev_redir) begin
            check("req_hold", {31'b0, mem_req}, 32'd1);
            check("addr_hold", mem_addr, prev_addr);
         end
         if (mem_req)
            check("req_gate", {31'b0, (int'(queue_count) + pend < DEPTH)}, 32'd1);
         if (pend == 0 && int'(queue_count) < DEPTH)
            check("req_live", {31'b0, mem_req}, 32'd1);
      end
      // response channel
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (resp_addr_q.size() > 0 && resp_time_q[0] <= cyc && $urandom_range(99) < p_rv) begin
         mem_rvalid = 1'b1;
         mem_rdata  = word_of(resp_addr_q[0]);
         void'(resp_addr_q.pop_front());
         void'(resp_time_q.pop_front());
      end
      mem_gnt    = ($urandom_range(99) < p_gnt);
      inst_ready = ($urandom_range(99) < p_ready);
      redirect   = force_redir || ($urandom_range(999) < p_redir);
      if (redirect) begin
         if (force_redir) redirect_pc = force_pc;
         else begin
            case ($urandom_range(2))
               0:       redirect_pc = $urandom;
               1:       redirect_pc = 32'hFFFF_FFFE;
               default: redirect_pc = $urandom_range(255);
            endcase
         end
      end
      if (mem_req && mem_gnt) begin
         check("fetch_addr", mem_addr, exp_fetch);
         resp_addr_q.push_back(mem_addr);
         resp_time_q.push_back(cyc + $urandom_range(lat_max, lat_min));
         exp_fetch = exp_fetch + 1;
      end
      if (redirect) begin
         exp_fetch = redirect_pc;
         next_pc   = redirect_pc;
         exp_q.delete();
      end
      while (exp_q.size() < 8) begin
         exp_q.push_back(next_pc);
         next_pc = next_pc + 1;
      end
      prev_req   = mem_req;
      prev_gnt   = mem_gnt;
      prev_redir = redirect;
      prev_addr  = mem_addr;
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            if (inst_valid && inst_ready && !redirect) begin
               if (exp_q.size() == 0) begin
                  check("sb_empty", inst_pc, 32'hDEAD_BEEF);
               end else begin
                  e = exp_q.pop_front();
                  check("deliv_pc", inst_pc, e);
                  check("deliv_inst", curr_inst, word_of(e));
                  delivered++;
               end
            end
            if (!inst_valid) begin
               check("empty_inst_zero", curr_inst, 32'd0);
               check("empty_pc_zero", inst_pc, 32'd0);
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int first_req, first_val, guard;
      logic [W-1:0] a0;

      // reset state
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      check("rst_curr_inst", curr_inst, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      check("rst_count", {29'b0, queue_count}, 32'd0);
      check("rst_mem_addr", mem_addr, RESET_PC);
      rst = 1'b1;

      // streaming: gnt=1, 1-cycle memory, ready=1
      first_req = -1;
      first_val = -1;
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b0, '0);
         if (first_req < 0 && mem_req) first_req = cyc;
         if (first_val < 0 && inst_valid) first_val = cyc;
         check("t1_addr", mem_addr, RESET_PC + i);
      end
      check("t1_first_latency", first_val - first_req, 32'd2);

      // stalled grant: request and address must hold
      p_gnt = 0;
      repeat (4) drive_cycle(1'b0, '0);
      a0 = mem_addr;
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b0, '0);
         check("t5_req", {31'b0, mem_req}, 32'd1);
         check("t5_addr", mem_addr, a0);
      end
      p_gnt = 100;
      drive_cycle(1'b0, '0);
      drive_cycle(1'b0, '0);
      check("t5_advance", mem_addr, a0 + 1);

      // back-pressure fills the queue, then drains in order
      p_ready = 0;
      guard = 0;
      while (queue_count != 3'd4 && guard < 40) begin
         drive_cycle(1'b0, '0);
         guard++;
      end
      repeat (2) drive_cycle(1'b0, '0);
      check("t2_full", {29'b0, queue_count}, 32'd4);
      check("t2_req_off", {31'b0, mem_req}, 32'd0);
      check("t2_outst", resp_addr_q.size(), 32'd0);
      p_ready = 100;
      repeat (12) drive_cycle(1'b0, '0);

      // redirect with responses in flight
      lat_min = 3;
      lat_max = 3;
      repeat (5) drive_cycle(1'b0, '0);
      check("t3_inflight", {31'b0, (resp_addr_q.size() >= 2)}, 32'd1);
      drive_cycle(1'b1, 32'h40);
      drive_cycle(1'b0, '0);
      check("t3_flush", {31'b0, dbg_flush}, 32'd1);
      check("t3_no_valid", {31'b0, inst_valid}, 32'd0);
      repeat (15) drive_cycle(1'b0, '0);

      // randomized traffic
      p_gnt = 70; p_rv = 70; p_ready = 60; p_redir = 30;
      lat_min = 1; lat_max = 4;
      repeat (3000) drive_cycle(1'b0, '0);
      p_redir = 0; p_rv = 100;
      repeat (20) drive_cycle(1'b0, '0);

      // asynchronous reset with a partly full queue
      p_gnt = 100; p_ready = 0; lat_min = 1; lat_max = 1;
      guard = 0;
      while (queue_count != 3'd3 && guard < 40) begin
         drive_cycle(1'b0, '0);
         guard++;
      end
      check("t6_count3", {29'b0, queue_count}, 32'd3);
      #3;
      rst = 1'b0;
      #1;
      check("t6_mem_req", {31'b0, mem_req}, 32'd0);
      check("t6_inst_valid", {31'b0, inst_valid}, 32'd0);
      check("t6_curr_inst", curr_inst, 32'd0);
      check("t6_inst_pc", inst_pc, 32'd0);
      check("t6_count", {29'b0, queue_count}, 32'd0);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      p_ready = 100;
      drive_cycle(1'b0, '0);
      check("t6_restart_addr", mem_addr, RESET_PC);
      check("t6_restart_req", {31'b0, mem_req}, 32'd1);
      repeat (10) drive_cycle(1'b0, '0);

      check("progress", {31'b0, (delivered > 200)}, 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
